universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port en  input  1  operation enable; 0 forces HOLD regardless of mode.
REQ-006 SHALL have port mode  input  3  operation select (encodings in REQ-010).
REQ-007 SHALL have port d  input  WIDTH  parallel load data.
REQ-008 SHALL have ports sin_l and sin_r  input  1 each  serial-in for SHL (into bit 0) and for SHR (into bit WIDTH-1).
REQ-009 SHALL have ports q  output  WIDTH  register state; notq  output  WIDTH  bitwise complement of q; sout_l  output  1  = q[WIDTH-1]; sout_r  output  1  = q[0].

Function
REQ-010 SHALL decode mode as: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR.
REQ-011 HOLD SHALL keep q unchanged.
REQ-012 LOAD SHALL set q <= d one cycle after the sampling edge (latency 1).
REQ-013 SHL SHALL set q <= {q[WIDTH-2:0], sin_l}.
REQ-014 SHR SHALL set q <= {sin_r, q[WIDTH-1:1]}.
REQ-015 ROL SHALL set q <= {q[WIDTH-2:0], q[WIDTH-1]}; ROR SHALL set q <= {q[0], q[WIDTH-1:1]}.
REQ-016 ASR SHALL set q <= {q[WIDTH-1], q[WIDTH-1:1]} (sign bit replicated, sin_r ignored).
REQ-017 CLR SHALL set q <= 0 (all zeros, independent of RESET_VALUE).
REQ-018 Exactly one operation SHALL apply per cycle; no multi-bit shifts.
REQ-019 notq SHALL equal ~q at all times, including during and immediately after reset; no cycle of skew.
REQ-020 sout_l and sout_r SHALL be combinational taps of current q (bit shifted out on the next SHL/SHR is visible before the edge).
REQ-021 Shifts at boundaries SHALL discard the bit leaving the register (SHL drops q[WIDTH-1], SHR drops q[0]); rotates SHALL lose no bits.
REQ-022 Output state SHALL depend only on clocked state; d, sin_l, sin_r SHALL have no combinational path to q or notq.

Reset
REQ-023 When rst_n=0 at a rising clk edge, q SHALL become RESET_VALUE and notq ~RESET_VALUE, overriding en and mode.
REQ-024 Reset SHALL have priority over every operation, including a LOAD issued in the same cycle.
REQ-025 Reset asserted mid-sequence (e.g. during rotate train) SHALL abort it; first operation after rst_n returns to 1 acts on RESET_VALUE.
REQ-026 rst_n SHALL have no effect between clock edges (purely synchronous).

Structure
REQ-027 Shared package shift_reg_pkg SHALL hold the mode typedef (3-bit enum with the REQ-010 names) and the MODE_W constant.
REQ-028 One sub-module dff_cell (1-bit D flip-flop, synchronous active-low reset to a per-bit init value, q and notq outputs) SHALL be instantiated WIDTH times via generate; next-state mux logic SHALL live in universal_shift_reg.

Verification
REQ-029 Reset: WIDTH=8, RESET_VALUE=8'hA5, rst_n=0 one edge -> q=8'hA5, notq=8'h5A; with en=1 mode=LOAD d=8'hFF at the same edge -> still 8'hA5.
REQ-030 Load/hold: LOAD d=8'h3C, then en=0 mode=SHL for 3 cycles -> q stays 8'h3C, notq 8'hC3.
REQ-031 Shifts: q=8'h81, SHL sin_l=0 -> 8'h02; from 8'h81 SHR sin_r=1 -> 8'hC0; sout_l/sout_r match q[7]/q[0] each cycle.
REQ-032 Rotate: q=8'h81, ROL 8 cycles -> returns to 8'h81 with intermediate 8'h03 after first; ROR once from 8'h81 -> 8'hC0.
REQ-033 ASR/CLR: q=8'h90, ASR -> 8'hC8, ASR -> 8'hE4; CLR -> 8'h00, notq 8'hFF.
REQ-034 Reset mid-operation: rotating 8'h81 under ROL, rst_n=0 at cycle 3 -> q=RESET_VALUE next edge; after release ROL -> rotate of RESET_VALUE; repeat with WIDTH=2 and WIDTH=64 for boundary widths.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared mode encoding for the universal shift register.
package shift_reg_pkg;

   localparam int unsigned MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      HOLD = 3'b000,
      LOAD = 3'b001,
      SHL  = 3'b010,
      SHR  = 3'b011,
      ROL  = 3'b100,
      ROR  = 3'b101,
      ASR  = 3'b110,
      CLR  = 3'b111
   } mode_e;

endpackage

// File: rtl/dff_cell.sv
// One-bit D flip-flop with synchronous active-low reset to INIT and a complement output.
module dff_cell #(
   parameter bit INIT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic notq
);

   logic q_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= INIT;
      end else begin
         q_q <= d;
      end
   end

   assign q    = q_q;
   // Derived from the same flop so notq can never lag q.
   assign notq = ~q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/arith-shift/clear, one operation per cycle.
module universal_shift_reg
   import shift_reg_pkg::*;
#(
   parameter int unsigned          WIDTH       = 8,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin_l,
   input  logic              sin_r,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  notq,
   output logic              sout_l,
   output logic              sout_r
);

   mode_e            op;
   logic [WIDTH-1:0] q_d;

   assign op = en ? mode_e'(mode) : HOLD;

   always_comb begin
      q_d = q;
      unique case (op)
         HOLD:    q_d = q;
         LOAD:    q_d = d;
         SHL:     q_d = {q[WIDTH-2:0], sin_l};
         SHR:     q_d = {sin_r, q[WIDTH-1:1]};
         ROL:     q_d = {q[WIDTH-2:0], q[WIDTH-1]};
         ROR:     q_d = {q[0], q[WIDTH-1:1]};
         ASR:     q_d = {q[WIDTH-1], q[WIDTH-1:1]};
         CLR:     q_d = '0;
         default: q_d = q;
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      dff_cell #(
         .INIT (RESET_VALUE[i])
      ) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (q_d[i]),
         .q     (q[i]),
         .notq  (notq[i])
      );
   end

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at widths 8, 2 and 64.
module tb_universal_shift_reg;

   localparam logic [7:0]  RV8  = 8'hA5;
   localparam logic [1:0]  RV2  = 2'b10;
   localparam logic [63:0] RV64 = 64'hDEAD_BEEF_0123_4567;

   localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010, M_SHR = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100, M_ROR  = 3'b101, M_ASR = 3'b110, M_CLR = 3'b111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 8-bit instance
   logic       rst_n8 = 1'b0, en8 = 1'b0, sl8 = 1'b0, sr8 = 1'b0;
   logic [2:0] mode8 = 3'b000;
   logic [7:0] d8 = '0, q8, nq8;
   logic       so_l8, so_r8;

   // 2-bit instance
   logic       rst_n2 = 1'b0, en2 = 1'b0, sl2 = 1'b0, sr2 = 1'b0;
   logic [2:0] mode2 = 3'b000;
   logic [1:0] d2 = '0, q2, nq2;
   logic       so_l2, so_r2;

   // 64-bit instance
   logic        rst_n64 = 1'b0, en64 = 1'b0, sl64 = 1'b0, sr64 = 1'b0;
   logic [2:0]  mode64 = 3'b000;
   logic [63:0] d64 = '0, q64, nq64;
   logic        so_l64, so_r64;

   universal_shift_reg #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
      .clk(clk), .rst_n(rst_n8), .en(en8), .mode(mode8), .d(d8), .sin_l(sl8), .sin_r(sr8),
      .q(q8), .notq(nq8), .sout_l(so_l8), .sout_r(so_r8)
   );

   universal_shift_reg #(.WIDTH(2), .RESET_VALUE(RV2)) u_dut2 (
      .clk(clk), .rst_n(rst_n2), .en(en2), .mode(mode2), .d(d2), .sin_l(sl2), .sin_r(sr2),
      .q(q2), .notq(nq2), .sout_l(so_l2), .sout_r(so_r2)
   );

   universal_shift_reg #(.WIDTH(64), .RESET_VALUE(RV64)) u_dut64 (
      .clk(clk), .rst_n(rst_n64), .en(en64), .mode(mode64), .d(d64), .sin_l(sl64),
      .sin_r(sr64), .q(q64), .notq(nq64), .sout_l(so_l64), .sout_r(so_r64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rol_exp [8];

   initial begin
      rol_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

      // ---- 8-bit: reset beats a same-edge LOAD
      rst_n8 = 1'b0; en8 = 1'b1; mode8 = M_LOAD; d8 = 8'hFF;
      tick();
      chk("rst_q", q8, 8'hA5);
      chk("rst_notq", nq8, 8'h5A);

      // load then disabled SHL holds
      rst_n8 = 1'b1; mode8 = M_LOAD; d8 = 8'h3C;
      tick();
      chk("load_3c", q8, 8'h3C);
      en8 = 1'b0; mode8 = M_SHL; sl8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("en0_hold_q", q8, 8'h3C);
         chk("en0_hold_notq", nq8, 8'hC3);
      end
      en8 = 1'b1; mode8 = M_HOLD;
      tick();
      chk("hold_mode", q8, 8'h3C);

      // rst_n pulse between edges has no effect
      #2 rst_n8 = 1'b0;
      #2 chk("async_rst_ignored", q8, 8'h3C);
      rst_n8 = 1'b1;

      // SHL / SHR with serial taps
      mode8 = M_LOAD; d8 = 8'h81;
      tick();
      chk("sout_l_81", so_l8, 1'b1);
      chk("sout_r_81", so_r8, 1'b1);
      mode8 = M_SHL; sl8 = 1'b0;
      tick();
      chk("shl_81", q8, 8'h02);
      chk("sout_l_02", so_l8, 1'b0);
      chk("sout_r_02", so_r8, 1'b0);
      mode8 = M_LOAD; d8 = 8'h81;
      tick();
      mode8 = M_SHR; sr8 = 1'b1;
      tick();
      chk("shr_81", q8, 8'hC0);
      chk("sout_l_c0", so_l8, 1'b1);
      chk("sout_r_c0", so_r8, 1'b0);

      // ROL full circle
      mode8 = M_LOAD; d8 = 8'h81;
      tick();
      mode8 = M_ROL;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rol_train", q8, rol_exp[i]);
      end

      // ROR once
      mode8 = M_LOAD; d8 = 8'h81;
      tick();
      mode8 = M_ROR;
      tick();
      chk("ror_81", q8, 8'hC0);

      // ASR twice then CLR
      mode8 = M_LOAD; d8 = 8'h90; sr8 = 1'b0;
      tick();
      mode8 = M_ASR;
      tick();
      chk("asr_1", q8, 8'hC8);
      tick();
      chk("asr_2", q8, 8'hE4);
      mode8 = M_CLR;
      tick();
      chk("clr_q", q8, 8'h00);
      chk("clr_notq", nq8, 8'hFF);

      // reset during a rotate train
      mode8 = M_LOAD; d8 = 8'h81;
      tick();
      mode8 = M_ROL;
      tick();
      chk("rol_mid_1", q8, 8'h03);
      tick();
      chk("rol_mid_2", q8, 8'h06);
      rst_n8 = 1'b0;
      tick();
      chk("rol_rst_q", q8, 8'hA5);
      chk("rol_rst_notq", nq8, 8'h5A);
      rst_n8 = 1'b1;
      tick();
      chk("rol_after_rst", q8, 8'h4B);

      // ---- 2-bit boundary width
      rst_n2 = 1'b0; en2 = 1'b1; mode2 = M_ROL;
      tick();
      chk("w2_rst", q2, 2'b10);
      chk("w2_rst_notq", nq2, 2'b01);
      rst_n2 = 1'b1; mode2 = M_LOAD; d2 = 2'b01;
      tick();
      mode2 = M_SHL; sl2 = 1'b1;
      tick();
      chk("w2_shl", q2, 2'b11);
      mode2 = M_SHR; sr2 = 1'b0;
      tick();
      chk("w2_shr", q2, 2'b01);
      mode2 = M_ROL;
      tick();
      chk("w2_rol_1", q2, 2'b10);
      tick();
      chk("w2_rol_2", q2, 2'b01);
      rst_n2 = 1'b0;
      tick();
      chk("w2_rol_rst", q2, 2'b10);
      rst_n2 = 1'b1;
      tick();
      chk("w2_rol_after", q2, 2'b01);
      mode2 = M_LOAD; d2 = 2'b10;
      tick();
      mode2 = M_ASR;
      tick();
      chk("w2_asr", q2, 2'b11);

      // ---- 64-bit boundary width
      rst_n64 = 1'b0; en64 = 1'b1; mode64 = M_LOAD; d64 = '1;
      tick();
      chk("w64_rst", q64, RV64);
      chk("w64_rst_notq", nq64, 64'h2152_4110_FEDC_BA98);
      rst_n64 = 1'b1; d64 = 64'h8000_0000_0000_0001;
      tick();
      chk("w64_sout_l", so_l64, 1'b1);
      mode64 = M_ROL;
      tick();
      chk("w64_rol_1", q64, 64'h0000_0000_0000_0003);
      tick();
      chk("w64_rol_2", q64, 64'h0000_0000_0000_0006);
      rst_n64 = 1'b0;
      tick();
      chk("w64_rol_rst", q64, RV64);
      rst_n64 = 1'b1;
      tick();
      chk("w64_rol_after", q64, 64'hBD5B_7DDE_0246_8ACF);
      mode64 = M_ROR;
      tick();
      chk("w64_ror_back", q64, RV64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
